// File: rtl/data_mem_responder.sv
// Byte-addressed RV64 data memory with a request/response handshake, fixed response latency
// and legality checks (alignment, range, funct3) on every request.
module data_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q;
    logic        error_q;

    logic [7:0]    mem [DEPTH_BYTES];
    logic          accept;
    logic          misaligned;
    logic          out_of_range;
    logic          req_err;
    logic [7:0]    byte_en;
    logic [AW-1:0] base;
    logic [63:0]   raw;
    logic [63:0]   load_val;

    assign accept = (state_q == StIdle) && req_valid && !reset;
    assign base   = req_addr[AW-1:0];

    always_comb begin
        byte_en    = 8'hFF;
        misaligned = 1'b0;
        unique case (req_funct3[1:0])
            2'b00: begin byte_en = 8'h01; misaligned = 1'b0;            end
            2'b01: begin byte_en = 8'h03; misaligned = req_addr[0];     end
            2'b10: begin byte_en = 8'h0F; misaligned = |req_addr[1:0];  end
            default: begin byte_en = 8'hFF; misaligned = |req_addr[2:0]; end
        endcase
    end

    // An aligned access below DEPTH_BYTES always fits, so only the high bits need checking.
    assign out_of_range = |req_addr[63:AW];
    assign req_err = misaligned | out_of_range | (req_funct3 == 3'b111)
                   | (req_write & req_funct3[2]);

    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++) begin
            raw[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    always_comb begin
        case (req_funct3)
            3'b000:  load_val = {{56{raw[7]}}, raw[7:0]};
            3'b001:  load_val = {{48{raw[15]}}, raw[15:0]};
            3'b010:  load_val = {{32{raw[31]}}, raw[31:0]};
            3'b100:  load_val = {56'd0, raw[7:0]};
            3'b101:  load_val = {48'd0, raw[15:0]};
            3'b110:  load_val = {32'd0, raw[31:0]};
            default: load_val = raw;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[base + AW'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                error_q <= req_err;
                rdata_q <= (req_err || req_write) ? 64'd0 : load_val;
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, backpressure/reset/zero-latency
// sequences, and random traffic against a byte-array reference model.
module tb_data_mem_responder;

    localparam int unsigned Depth = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_ready, resp_valid, resp_error;
    logic [63:0] resp_rdata;

    logic        req_valid0 = 1'b0, req_write0 = 1'b0;
    logic [63:0] req_addr0 = '0, req_wdata0 = '0;
    logic [2:0]  req_funct30 = '0;
    logic        req_ready0, resp_valid0, resp_error0;
    logic [63:0] resp_rdata0;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_model [Depth];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_BYTES(Depth), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    data_mem_responder #(.DEPTH_BYTES(Depth), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .req_funct3(req_funct30), .resp_valid(resp_valid0), .resp_ready(1'b1),
        .resp_rdata(resp_rdata0), .resp_error(resp_error0)
    );

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  f3;
        logic [63:0] exp_rd;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: expected response from the size/alignment/range rules, plus store effect.
    task automatic model_apply(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [2:0] f3, output logic [63:0] rd, output bit err);
        int unsigned sz = 1 << f3[1:0];
        int unsigned base;
        err = ((addr % 64'(sz)) != 0) || (addr > 64'(Depth - sz)) || (f3 == 3'b111)
              || (wr && f3[2]);
        rd = '0;
        if (!err) begin
            base = int'(addr[9:0]);
            if (wr) begin
                for (int i = 0; i < int'(sz); i++) mem_model[base + i] = 8'(wdata >> (8 * i));
            end else begin
                for (int i = 0; i < int'(sz); i++) rd |= 64'(mem_model[base + i]) << (8 * i);
                if (!f3[2] && sz < 8 && rd[8*sz-1]) rd |= ~((64'd1 << (8 * sz)) - 64'd1);
            end
        end
    endtask

    // One full transaction on the LATENCY=2 instance; lat counts edges from the accept edge.
    task automatic do_req(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [2:0] f3, output logic [63:0] rd, output logic err,
                          output int lat);
        @(negedge clk);
        check("req_ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = resp_rdata;
        err = resp_error;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    vec_t        vecs [16];
    logic [63:0] rd, mrd, hold_rd, data;
    logic        err;
    bit          merr;
    int          lat, nresp;

    initial begin
        vecs[0]  = '{1, 64'h10,  64'h8877665544332211, 3'b011, 64'h0, 0};
        vecs[1]  = '{0, 64'h10,  64'h0, 3'b011, 64'h8877665544332211, 0};
        vecs[2]  = '{0, 64'h17,  64'h0, 3'b000, 64'hFFFFFFFFFFFFFF88, 0};
        vecs[3]  = '{0, 64'h17,  64'h0, 3'b100, 64'h0000000000000088, 0};
        vecs[4]  = '{0, 64'h12,  64'h0, 3'b001, 64'h0000000000004433, 0};
        vecs[5]  = '{0, 64'h12,  64'h0, 3'b010, 64'h0, 1};
        vecs[6]  = '{1, 64'd1024, 64'hAB, 3'b000, 64'h0, 1};
        vecs[7]  = '{0, 64'h10,  64'h0, 3'b011, 64'h8877665544332211, 0};
        vecs[8]  = '{0, 64'h14,  64'h0, 3'b010, 64'hFFFFFFFF88776655, 0};
        vecs[9]  = '{0, 64'h16,  64'h0, 3'b101, 64'h0000000000008877, 0};
        vecs[10] = '{0, 64'h10,  64'h0, 3'b111, 64'h0, 1};
        vecs[11] = '{1, 64'h10,  64'h55, 3'b100, 64'h0, 1};
        vecs[12] = '{0, 64'h0000_0001_0000_0010, 64'h0, 3'b011, 64'h0, 1};
        vecs[13] = '{1, 64'h3F8, 64'h0123456789ABCDEF, 3'b011, 64'h0, 0};
        vecs[14] = '{0, 64'h3F8, 64'h0, 3'b011, 64'h0123456789ABCDEF, 0};
        vecs[15] = '{0, 64'h3FC, 64'h0, 3'b010, 64'h0000000001234567, 0};

        // Reset state, checked while reset is still asserted.
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_resp_valid", 64'(resp_valid), 64'd0);
        check("reset_resp_rdata", resp_rdata, 64'd0);
        check("reset_resp_error", 64'(resp_error), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Give the low 256 bytes defined contents.
        for (int a = 0; a < 256; a += 8) begin
            data = {$urandom(), $urandom()};
            do_req(1'b1, 64'(a), data, 3'b011, rd, err, lat);
            model_apply(1'b1, 64'(a), data, 3'b011, mrd, merr);
            check("init_store_err", 64'(err), 64'd0);
        end

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, err, lat);
            model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3, mrd, merr);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_error", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
        end

        // Backpressure: response held for 5 cycles with resp_ready low.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_funct3 = 3'b011;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        hold_rd = resp_rdata;
        check("bp_rdata", hold_rd, 64'h8877665544332211);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_resp_valid", 64'(resp_valid), 64'd1);
            check("bp_rdata_stable", resp_rdata, hold_rd);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_ready_after", 64'(req_ready), 64'd1);
        check("bp_valid_after", 64'(resp_valid), 64'd0);

        // Reset during WAIT after a committed store; a request during reset is ignored.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20;
        req_wdata = 64'hDEADBEEF; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_apply(1'b1, 64'h20, 64'hDEADBEEF, 3'b010, mrd, merr);
        check("rst_in_wait", 64'(req_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("rst_async_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_async_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20;
        req_wdata = 64'hFF; req_funct3 = 3'b000;
        @(posedge clk); #1;
        check("rst_no_accept", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        do_req(1'b0, 64'h20, 64'h0, 3'b110, rd, err, lat);
        check("rst_lwu_rdata", rd, 64'h00000000DEADBEEF);
        check("rst_lwu_error", 64'(err), 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            bit          wr = 1'($urandom_range(0, 1));
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [63:0] addr;
            int          r = int'($urandom_range(0, 9));
            if (r < 7)      addr = 64'($urandom_range(0, 255));
            else if (r < 9) addr = 64'($urandom_range(1016, 1031));
            else            addr = 64'h1_0000_0000 | 64'($urandom_range(0, 63));
            data = {$urandom(), $urandom()};
            do_req(wr, addr, data, f3, rd, err, lat);
            model_apply(wr, addr, data, f3, mrd, merr);
            check($sformatf("rnd%0d_rdata", n), rd, mrd);
            check($sformatf("rnd%0d_error", n), 64'(err), 64'(merr));
            check($sformatf("rnd%0d_latency", n), 64'(lat), 64'd3);
        end

        // LATENCY=0 instance: accept, response, next accept on consecutive edges.
        @(negedge clk);
        check("l0_ready_idle", 64'(req_ready0), 64'd1);
        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 64'h8;
        req_wdata0 = 64'hCAFEF00D12345678; req_funct30 = 3'b011;
        @(posedge clk); #1;
        check("l0_store_resp_valid", 64'(resp_valid0), 64'd1);
        check("l0_store_req_ready", 64'(req_ready0), 64'd0);
        check("l0_store_error", 64'(resp_error0), 64'd0);
        req_write0 = 1'b0;
        @(posedge clk); #1;
        check("l0_idle_resp_valid", 64'(resp_valid0), 64'd0);
        check("l0_idle_req_ready", 64'(req_ready0), 64'd1);
        @(posedge clk); #1;
        check("l0_load_resp_valid", 64'(resp_valid0), 64'd1);
        check("l0_load_rdata", resp_rdata0, 64'hCAFEF00D12345678);
        nresp = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (resp_valid0) nresp++;
        end
        check("l0_throughput", 64'(nresp), 64'd4);
        req_valid0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
